// File: rtl/gbuf_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gbuf_port_arbiter_if
// Purpose  : Requester-side and Global Buffer-side bus of the port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface gbuf_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          gb_chip_en;
    logic                          gb_ren;
    logic                          gb_wen;
    logic [ADDR_WIDTH-1:0]         gb_raddr;
    logic [ADDR_WIDTH-1:0]         gb_waddr;
    logic [DATA_WIDTH-1:0]         gb_din;
    logic [DATA_WIDTH-1:0]         gb_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, gb_dout,
        output req_ready, rsp_valid, rsp_data,
        output gb_chip_en, gb_ren, gb_wen, gb_raddr, gb_waddr, gb_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, gb_dout,
        input  req_ready, rsp_valid, rsp_data,
        input  gb_chip_en, gb_ren, gb_wen, gb_raddr, gb_waddr, gb_din
    );
endinterface
`default_nettype wire

// File: rtl/gbuf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gbuf_port_arbiter
// Purpose  : Independent round-robin read/write arbitration of the Global
//            Buffer ports. Optional macro GBUF_ARB_RAW_BYPASS_EN forwards
//            same-cycle write data to a colliding read.
// Revision : 1.0 - initial release
// ============================================================================
module gbuf_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               arb_en,
    gbuf_port_arbiter_if.slave bus
);

    localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ - 1);

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    // Returns {found, index}: first candidate at or above ptr, wrapping.
    function automatic logic [c_PTR_W:0] f_pick(input logic [NUM_REQ-1:0] cand,
                                                input logic [c_PTR_W-1:0] ptr);
        logic [c_PTR_W-1:0] idx;
        logic [c_PTR_W-1:0] sel;
        logic               found;
        idx   = ptr;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
            idx = f_inc(idx);
        end
        return {found, sel};
    endfunction

    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic                  r_rsp_pend;
    logic [c_PTR_W-1:0]    r_rsp_idx;

    logic [NUM_REQ-1:0]    w_rd_cand;
    logic [NUM_REQ-1:0]    w_wr_cand;
    logic                  w_rd_found;
    logic                  w_wr_found;
    logic [c_PTR_W-1:0]    w_rd_idx;
    logic [c_PTR_W-1:0]    w_wr_idx;
    logic                  w_grant_ok;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic [NUM_REQ-1:0]    w_ready;
    logic [NUM_REQ-1:0]    w_rsp_valid;
    logic [DATA_WIDTH-1:0] w_rsp_word;

    assign w_rd_cand = bus.req_valid & ~bus.req_we;
    assign w_wr_cand = bus.req_valid &  bus.req_we;

    assign {w_rd_found, w_rd_idx} = f_pick(w_rd_cand, r_rd_ptr);
    assign {w_wr_found, w_wr_idx} = f_pick(w_wr_cand, r_wr_ptr);

    // Grants are suppressed while reset is asserted, not only after the first edge.
    assign w_grant_ok = arb_en & rstn;
    assign w_rd_gnt   = w_rd_found & w_grant_ok;
    assign w_wr_gnt   = w_wr_found & w_grant_ok;

    always_comb begin
        w_ready = '0;
        if (w_rd_gnt) w_ready[w_rd_idx] = 1'b1;
        if (w_wr_gnt) w_ready[w_wr_idx] = 1'b1;
    end

    assign bus.req_ready  = w_ready;
    assign bus.gb_ren     = w_rd_gnt;
    assign bus.gb_wen     = w_wr_gnt;
    assign bus.gb_chip_en = w_rd_gnt | w_wr_gnt;
    assign bus.gb_raddr   = w_rd_gnt ? bus.req_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.gb_waddr   = w_wr_gnt ? bus.req_addr[w_wr_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.gb_din     = w_wr_gnt ? bus.req_wdata[w_wr_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_rd_gnt) r_rd_ptr <= f_inc(w_rd_idx);
            if (w_wr_gnt) r_wr_ptr <= f_inc(w_wr_idx);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_pend <= 1'b0;
            r_rsp_idx  <= '0;
        end else begin
            r_rsp_pend <= w_rd_gnt;
            if (w_rd_gnt) r_rsp_idx <= w_rd_idx;
        end
    end

`ifdef GBUF_ARB_RAW_BYPASS_EN
    logic                  r_byp_hit;
    logic [DATA_WIDTH-1:0] r_byp_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit <= w_rd_gnt & w_wr_gnt & (bus.gb_raddr == bus.gb_waddr);
            if (w_rd_gnt & w_wr_gnt) r_byp_data <= bus.gb_din;
        end
    end

    assign w_rsp_word = r_byp_hit ? r_byp_data : bus.gb_dout;
`else
    assign w_rsp_word = bus.gb_dout;
`endif

    always_comb begin
        w_rsp_valid = '0;
        if (r_rsp_pend) w_rsp_valid[r_rsp_idx] = 1'b1;
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_rsp_pend ? w_rsp_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_gbuf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gbuf_port_arbiter
// Purpose  : Directed vector bench for gbuf_port_arbiter with a buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gbuf_port_arbiter;

    logic clk = 1'b0;
    logic rstn;
    logic arb_en;
    logic mem_clear;

    int total = 0;
    int bad   = 0;

    gbuf_port_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(13)) bus ();

    gbuf_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(13)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .arb_en (arb_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [8:0] a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    // Buffer model: registered read, read-before-write on collision.
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int a = 0; a < 512; a++) mem[a] <= pat(9'(a));
        end else begin
            if (bus.gb_ren) bus.gb_dout <= mem[bus.gb_raddr[8:0]];
            if (bus.gb_wen) mem[bus.gb_waddr[8:0]] <= bus.gb_din;
        end
    end

    logic [12:0] addr_of [4];
    logic [31:0] wd_of   [4];

    task automatic set_req(input int i, input logic [12:0] a, input logic [31:0] d);
        bus.req_addr[i*13 +: 13]  = a;
        bus.req_wdata[i*32 +: 32] = d;
        addr_of[i] = a;
        wd_of[i]   = d;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic en, input logic [3:0] v,
                       input logic [3:0] w, input logic [3:0] rdy,
                       input logic [3:0] rv, input logic [31:0] d);
        logic [12:0] era;
        logic [12:0] ewa;
        logic [31:0] ed;
        arb_en        = en;
        bus.req_valid = v;
        bus.req_we    = w;
        era = '0;
        ewa = '0;
        ed  = '0;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i] && !w[i]) era = addr_of[i];
            if (rdy[i] && w[i]) begin
                ewa = addr_of[i];
                ed  = wd_of[i];
            end
        end
        @(negedge clk);
        chk({nm, " ready"},     32'(bus.req_ready),  32'(rdy));
        chk({nm, " rsp_valid"}, 32'(bus.rsp_valid),  32'(rv));
        chk({nm, " rsp_data"},  bus.rsp_data,        d);
        chk({nm, " gb_ren"},    32'(bus.gb_ren),     32'(|(rdy & ~w)));
        chk({nm, " gb_wen"},    32'(bus.gb_wen),     32'(|(rdy & w)));
        chk({nm, " chip_en"},   32'(bus.gb_chip_en), 32'(|rdy));
        chk({nm, " gb_raddr"},  32'(bus.gb_raddr),   32'(era));
        chk({nm, " gb_waddr"},  32'(bus.gb_waddr),   32'(ewa));
        chk({nm, " gb_din"},    bus.gb_din,          ed);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rv;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [15];

    localparam logic [31:0] c_HAZ =
`ifdef GBUF_ARB_RAW_BYPASS_EN
        32'h2222_2222;
`else
        32'h1111_1111;
`endif

    initial begin
        // Requester i: address 0x100+i, write data 0xC0DE0000+i.
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 32'h0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 32'hA5A5_0100};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 4'b0010, 32'hA5A5_0101};
        tbl[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b0100, 32'hA5A5_0102};
        tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b1000, 32'hA5A5_0103};
        tbl[5]  = '{1'b1, 4'b1111, 4'b1010, 4'b0110, 4'b0001, 32'hA5A5_0100};
        tbl[6]  = '{1'b1, 4'b1111, 4'b1010, 4'b1001, 4'b0100, 32'hA5A5_0102};
        tbl[7]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 32'hA5A5_0100};
        tbl[8]  = '{1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b0010, 32'hC0DE_0001};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 32'hC0DE_0003};
        tbl[10] = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h0};
        tbl[11] = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 32'h0};
        tbl[12] = '{1'b1, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 32'h0};
        tbl[13] = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 32'h0};
        tbl[14] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'hC0DE_0000};

        rstn          = 1'b0;
        arb_en        = 1'b1;
        mem_clear     = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_we    = 4'b0000;
        for (int i = 0; i < 4; i++) set_req(i, 13'h100 + 13'(i), 32'hC0DE_0000 + 32'(i));

        repeat (2) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        chk("reset ready",     32'(bus.req_ready),  32'h0);
        chk("reset rsp_valid", 32'(bus.rsp_valid),  32'h0);
        chk("reset rsp_data",  bus.rsp_data,        32'h0);
        chk("reset gb_ren",    32'(bus.gb_ren),     32'h0);
        chk("reset gb_wen",    32'(bus.gb_wen),     32'h0);
        chk("reset chip_en",   32'(bus.gb_chip_en), 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;

        for (int r = 0; r < 15; r++)
            cyc($sformatf("vec%0d", r), tbl[r].en, tbl[r].valid, tbl[r].we,
                tbl[r].exp_ready, tbl[r].exp_rv, tbl[r].exp_data);

        // Concurrent read and write classes, then read back the written word.
        set_req(1, 13'h010, 32'hDEAD_BEEF);
        set_req(2, 13'h020, 32'h0);
        cyc("conc_a", 1'b1, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 32'h0);
        set_req(2, 13'h010, 32'h0);
        cyc("conc_b", 1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 32'hA5A5_0020);
        cyc("conc_c", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 32'hDEAD_BEEF);

        // Same-address read and write in one cycle.
        set_req(0, 13'h055, 32'h1111_1111);
        cyc("haz_d", 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 32'h0);
        set_req(0, 13'h055, 32'h2222_2222);
        set_req(1, 13'h055, 32'h0);
        cyc("haz_e", 1'b1, 4'b0011, 4'b0001, 4'b0011, 4'b0000, 32'h0);
        cyc("haz_f", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, c_HAZ);

        // Enable gating: pending response survives, no new grants.
        for (int i = 0; i < 4; i++) set_req(i, 13'h030 + 13'(i), 32'h0);
        set_req(3, 13'h030, 32'h0);
        set_req(0, 13'h030, 32'h0);
        cyc("gate_g", 1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 32'h0);
        cyc("gate_h", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 32'hA5A5_0030);
        cyc("gate_i", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 32'h0);
        cyc("gate_j", 1'b1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 32'h0);
        cyc("gate_k", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'hA5A5_0030);

        // Reset right after a read grant discards the response and the pointers.
        set_req(2, 13'h040, 32'h0);
        set_req(1, 13'h041, 32'h5A5A_5A5A);
        cyc("rst_l", 1'b1, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 32'h0);
        rstn = 1'b0;
        #1;
        chk("rst_m rsp_valid", 32'(bus.rsp_valid),  32'h0);
        chk("rst_m rsp_data",  bus.rsp_data,        32'h0);
        chk("rst_m ready",     32'(bus.req_ready),  32'h0);
        chk("rst_m chip_en",   32'(bus.gb_chip_en), 32'h0);
        bus.req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        cyc("rst_n", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);
        cyc("rst_o", 1'b1, 4'b1111, 4'b0101, 4'b0011, 4'b0000, 32'h0);
        cyc("rst_p", 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 32'h5A5A_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gbuf_port_arbiter.md
# gbuf_port_arbiter

Round-robin arbiter that shares the Global Buffer's single read port and single write port among `NUM_REQ` requesters (PE-array feeders, output drain, DMA loader). Read and write requests are arbitrated independently, so at most one read and one write are issued per cycle. The block drives the buffer's control, address and data pins and routes each registered read result back to the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 32: buffer word width.
- `ADDR_WIDTH`, 13: word address width (32 KB / 4 B).

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `arb_en`  in  1  when 0, no new grants are issued; a pending read response still completes.
- `req_valid`  in  NUM_REQ  request valid, one bit per requester.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data, sliced the same way.
- `req_ready`  out  NUM_REQ  grant, one-hot within the read class and within the write class.
- `rsp_valid`  out  NUM_REQ  one-hot read-data-valid.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all requesters.
- `gb_chip_en`  out  1  buffer chip enable; equals `gb_ren | gb_wen`.
- `gb_ren`, `gb_wen`  out  1  buffer read and write strobes.
- `gb_raddr`, `gb_waddr`  out  ADDR_WIDTH  buffer addresses.
- `gb_din`  out  DATA_WIDTH  buffer write data.
- `gb_dout`  in  DATA_WIDTH  buffer read data, registered inside the buffer.

## Operation
- Two request classes, each with its own round-robin pointer:
  - read candidates: `req_valid[i] & ~req_we[i]`
  - write candidates: `req_valid[i] & req_we[i]`
- Grant selection: the first candidate found searching upward from the pointer, wrapping from NUM_REQ-1 to 0.
- After a grant to i, that class's pointer becomes (i+1) mod NUM_REQ. A class with no grant keeps its pointer.
- A transfer occurs when `req_valid[i] & req_ready[i]`. A requester holds valid, we, addr and wdata stable until granted. Dropping valid before the grant is allowed and simply withdraws the request.
- `req_ready`, `gb_ren`, `gb_wen`, `gb_raddr`, `gb_waddr` and `gb_din` are combinational from the requests, the pointers and `arb_en`.
- Address and data outputs are 0 when their strobe is 0.
- Response tracking:
  - A granted read loads `rsp_pend=1` and `rsp_idx=i`.
  - In the next cycle, `rsp_valid[rsp_idx]=1` and `rsp_data=gb_dout`.
  - `rsp_pend` clears automatically unless a new read was granted in the same cycle. Back-to-back reads therefore give one response per cycle.
- `rsp_data` is 0 when no response is valid.
- Same-cycle read and write to the same address: the buffer returns the old data (read-before-write), unless the bypass feature is compiled in.
- Reset values: both pointers 0, `rsp_pend` 0, `rsp_valid` 0, `rsp_data` 0. All grants and `gb_*` strobes are forced to 0 while `rstn` is low.
- Reset mid-operation: a pending response is discarded and no `rsp_valid` is produced after reset releases.

## Timing
- Grant: same cycle as the request, with zero added latency.
- Read latency: the grant in cycle T produces `rsp_valid` and `rsp_data` in cycle T+1.
- Write: committed at the clock edge that ends the grant cycle. A read granted in any later cycle sees the new data.
- Throughput: 1 read plus 1 write per cycle. With all requesters continuously requesting one class, each requester is granted every NUM_REQ cycles.
- `arb_en` falling in cycle T: no grants in T or later. A response already pending from T-1 still appears in T.

## Configuration
- `GBUF_ARB_RAW_BYPASS_EN` defined:
  - If the granted read address equals the granted write address in the same cycle, the write data is registered.
  - The response in the next cycle returns that new data instead of `gb_dout`.
- Not defined: no compare logic, and `rsp_data` is always `gb_dout` (read-before-write).

## Test plan
- Reset: hold `rstn`=0 with all `req_valid`=1 -> every `req_ready`, `rsp_valid` and `gb_*` strobe is 0. After release, the first read grant goes to requester 0.
- Round-robin: requesters 0..3 all read continuously -> grants run 0,1,2,3,0 in consecutive cycles, and `rsp_valid` follows one cycle later in the same order.
- Concurrent classes: requester 1 writes 0xDEADBEEF to address 0x010 while requester 2 reads 0x020, same cycle -> both granted that cycle. Requester 2 then reads 0x010 and gets 0xDEADBEEF one cycle after its grant.
- Read-during-write hazard: a read and a write to 0x055 in the same cycle, with old value 0x11111111 and new 0x22222222 -> response is 0x11111111 without `GBUF_ARB_RAW_BYPASS_EN`, 0x22222222 with it.
- Enable gating: deassert `arb_en` in the cycle after a read grant to requester 3 -> requester 3 still gets its `rsp_valid`, then no further grants until `arb_en`=1.
- Reset mid-read: assert `rstn`=0 in the cycle after a read grant -> no `rsp_valid` for that read, and both pointers return to 0.
